// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Groups the handshake buses around the fetch stage:
//   imem_req_*  : fetch request to instruction memory (valid/ready)
//   imem_rsp_*  : in-order read data returned by instruction memory
//   redirect_*  : taken branch / jal / jalr target from execute
//   if_*        : head instruction presented to decode (valid/ready)
//   misalign_pulse : one-cycle flag for a redirect target with low bits set
// Modports:
//   master : the fetch unit itself
//   slave  : the environment (memory, execute, decode)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic [6:0]      if_opcode;
    logic [2:0]      if_funct3;
    logic [6:0]      if_funct7;
    logic            misalign_pulse;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output if_valid, if_pc, if_instr, if_opcode, if_funct3, if_funct7,
        input  if_ready,
        output misalign_pulse
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  if_valid, if_pc, if_instr, if_opcode, if_funct3, if_funct7,
        output if_ready,
        input  misalign_pulse
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage of the RV32I core. Owns the PC, issues word reads to instruction
// memory under a credit limit, buffers returned words (with their PCs) in a
// small in-order FIFO and presents the head entry to decode. Redirects from
// execute flush the FIFO and mark all outstanding fetches as stale.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous reset, active low
//   bus    : instr_fetch_unit_if.master (imem request/response, redirect,
//            decode handshake, misalign pulse)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // State registers
    logic [XLEN-1:0]  r_fetch_pc;
    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0] r_drop;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_pcq_wr;
    logic [PTR_W-1:0] r_pcq_rd;
    logic             r_misalign;

    // Storage: buffered words with their PCs, and PCs of in-flight requests
    logic [XLEN-1:0]  r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]      r_fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0]  r_pcq        [FIFO_DEPTH];

    // Next-state values
    logic [XLEN-1:0]  w_fetch_pc_next;
    logic [CNT_W-1:0] w_inflight_next;
    logic [CNT_W-1:0] w_drop_next;
    logic [CNT_W-1:0] w_count_next;
    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [PTR_W-1:0] w_pcq_wr_next;
    logic [PTR_W-1:0] w_pcq_rd_next;
    logic             w_misalign_next;

    // Handshake decodes
    logic [CNT_W:0]   w_credit_used;
    logic             w_req_valid;
    logic             w_accept;
    logic             w_rsp;
    logic             w_stale;
    logic             w_push;
    logic             w_pop;
    logic             w_if_valid;
    logic [31:0]      w_head_instr;
    logic [XLEN-1:0]  w_head_pc;

    // Credits cover both outstanding requests and buffered words, so every
    // accepted request is guaranteed a FIFO slot when its word returns.
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_req_valid   = rst_n & ~bus.redirect_valid
                         & (w_credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign w_accept      = w_req_valid & bus.imem_req_ready;

    // A response with nothing outstanding belongs to a request issued before
    // reset and is ignored.
    assign w_rsp         = bus.imem_rsp_valid & (r_inflight != '0);
    // A word arriving during a redirect is wrong-path even if drop is zero.
    assign w_stale       = w_rsp & (bus.redirect_valid | (r_drop != '0));
    assign w_push        = w_rsp & ~w_stale;
    assign w_if_valid    = (r_count != '0);
    // A handshake coinciding with a redirect is void: the entry is flushed.
    assign w_pop         = w_if_valid & bus.if_ready & ~bus.redirect_valid;

    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        w_inflight_next = r_inflight + CNT_W'(w_accept) - CNT_W'(w_rsp);
        w_drop_next     = r_drop;
        w_count_next    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_wr_ptr_next   = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
        w_rd_ptr_next   = w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
        w_pcq_wr_next   = w_accept ? r_pcq_wr + PTR_W'(1) : r_pcq_wr;
        w_pcq_rd_next   = w_rsp    ? r_pcq_rd + PTR_W'(1) : r_pcq_rd;
        w_misalign_next = 1'b0;

        if (bus.redirect_valid) begin
            w_fetch_pc_next = {bus.redirect_pc[XLEN-1:2], 2'b00};
            // Every outstanding request is wrong-path after a redirect; the
            // already-stale ones are a subset of inflight, so drop becomes
            // inflight rather than growing past it. The response consumed
            // this cycle (if any) is one of them.
            w_drop_next     = r_inflight - CNT_W'(w_rsp);
            w_count_next    = '0;
            w_wr_ptr_next   = '0;
            w_rd_ptr_next   = '0;
            w_misalign_next = (bus.redirect_pc[1:0] != 2'b00);
        end else begin
            if (w_accept) begin
                w_fetch_pc_next = r_fetch_pc + XLEN'(4);
            end
            if (w_stale) begin
                w_drop_next = r_drop - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pcq_wr   <= '0;
            r_pcq_rd   <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            r_inflight <= w_inflight_next;
            r_drop     <= w_drop_next;
            r_count    <= w_count_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_pcq_wr   <= w_pcq_wr_next;
            r_pcq_rd   <= w_pcq_rd_next;
            r_misalign <= w_misalign_next;
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        end
        if (rst_n && w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_pcq[r_pcq_rd];
            r_fifo_instr[r_wr_ptr] <= bus.imem_rsp_data;
        end
    end

    // Head fields read as zero when empty so nothing uninitialised leaks out.
    assign w_head_instr = w_if_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
    assign w_head_pc    = w_if_valid ? r_fifo_pc[r_rd_ptr]    : '0;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.if_valid       = w_if_valid;
    assign bus.if_pc          = w_head_pc;
    assign bus.if_instr       = w_head_instr;
    assign bus.if_opcode      = w_head_instr[6:0];
    assign bus.if_funct3      = w_head_instr[14:12];
    assign bus.if_funct7      = w_head_instr[31:25];
    assign bus.misalign_pulse = r_misalign;
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

    instr_fetch_unit #(
        .XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_pass = 0;
    int n_consumed = 0;
    int mem_lat = 1;
    int cyc = 0;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    pend_t pend[$];
    exp_t  sb[$];
    logic [31:0] exp_addr = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1233;
    endfunction

    // Memory model + request checker + scoreboard producer.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk); #3;
            if (!rst_n) begin
                pend.delete();
                sb.delete();
                exp_addr = RESET_PC;
            end else if (bus.redirect_valid) begin
                n_checks++;
                if (bus.imem_req_valid !== 1'b0)
                    $display("FAIL req_in_redirect: req_valid=%b required 0", bus.imem_req_valid);
                else n_pass++;
                sb.delete();
                exp_addr = {bus.redirect_pc[31:2], 2'b00};
            end else if (bus.imem_req_valid && bus.imem_req_ready) begin
                n_checks++;
                if (bus.imem_req_addr !== exp_addr)
                    $display("FAIL req_addr: got %h required %h", bus.imem_req_addr, exp_addr);
                else n_pass++;
                pend.push_back('{bus.imem_req_addr, cyc + mem_lat});
                sb.push_back('{exp_addr, mem_word(exp_addr)});
                exp_addr = exp_addr + 32'd4;
            end
            @(posedge clk); cyc++; #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = 32'h0;
            end
        end
    end

    // Scoreboard consumer and head-stability checker.
    initial begin
        logic        stall_prev;
        logic [31:0] held_pc, held_instr;
        exp_t        e;
        stall_prev = 1'b0;
        held_pc = '0;
        held_instr = '0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n || bus.redirect_valid) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    n_checks++;
                    if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, held_pc, held_instr})
                        $display("FAIL head_stable: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                                 bus.if_valid, bus.if_pc, bus.if_instr, held_pc, held_instr);
                    else n_pass++;
                end
                if (bus.if_valid && bus.if_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL unexpected_output: got pc=%h required no output", bus.if_pc);
                    end else begin
                        e = sb.pop_front();
                        if ({bus.if_pc, bus.if_instr, bus.if_opcode, bus.if_funct3, bus.if_funct7} !==
                            {e.pc, e.instr, e.instr[6:0], e.instr[14:12], e.instr[31:25]})
                            $display("FAIL if_output: got pc=%h instr=%h op=%h f3=%h f7=%h required pc=%h instr=%h",
                                     bus.if_pc, bus.if_instr, bus.if_opcode, bus.if_funct3,
                                     bus.if_funct7, e.pc, e.instr);
                        else n_pass++;
                    end
                    n_consumed++;
                    $display("consume pc=%h instr=%h", bus.if_pc, bus.if_instr);
                end
                stall_prev = bus.if_valid && !bus.if_ready;
                held_pc    = bus.if_pc;
                held_instr = bus.if_instr;
            end
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_valid(input string name, output logic found, output logic [31:0] pc);
        found = 1'b0;
        pc = '0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (bus.if_valid) begin
                found = 1'b1;
                pc = bus.if_pc;
            end
        end
        if (!found) $display("%s: no if_valid within 30 cycles", name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.if_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({bus.imem_req_valid, bus.imem_req_addr, bus.misalign_pulse} !== {1'b0, RESET_PC, 1'b0})
            $display("FAIL reset_req: got v=%b addr=%h mis=%b required v=0 addr=%h mis=0",
                     bus.imem_req_valid, bus.imem_req_addr, bus.misalign_pulse, RESET_PC);
        else n_pass++;
        n_checks++;
        if ({bus.if_valid, bus.if_pc, bus.if_instr, bus.if_opcode, bus.if_funct3, bus.if_funct7} !== '0)
            $display("FAIL reset_if: got v=%b pc=%h instr=%h required all 0",
                     bus.if_valid, bus.if_pc, bus.if_instr);
        else n_pass++;
    endtask

    task automatic test_stream();
        int c0;
        mem_lat = 1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({bus.imem_req_valid, bus.imem_req_addr, bus.if_valid} !== {1'b1, RESET_PC, 1'b0})
            $display("FAIL first_req: got v=%b addr=%h ifv=%b required v=1 addr=%h ifv=0",
                     bus.imem_req_valid, bus.imem_req_addr, bus.if_valid, RESET_PC);
        else n_pass++;
        step();
        n_checks++;
        if (bus.if_valid !== 1'b0) $display("FAIL cycle2_if_valid: got %b required 0", bus.if_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({bus.if_valid, bus.if_pc} !== {1'b1, RESET_PC})
            $display("FAIL cycle3_if: got v=%b pc=%h required v=1 pc=%h", bus.if_valid, bus.if_pc, RESET_PC);
        else n_pass++;
        c0 = n_consumed;
        repeat (20) step();
        n_checks++;
        if (n_consumed - c0 < 10) $display("FAIL stream_rate: got %0d required >=10", n_consumed - c0);
        else n_pass++;
    endtask

    task automatic test_stall();
        int c0;
        bus.if_ready = 1'b0;
        repeat (5) step();
        n_checks++;
        if ({bus.imem_req_valid, bus.if_valid} !== 2'b01)
            $display("FAIL stall_full: got req_v=%b if_v=%b required req_v=0 if_v=1",
                     bus.imem_req_valid, bus.if_valid);
        else n_pass++;
        c0 = n_consumed;
        bus.if_ready = 1'b1;
        repeat (10) step();
        n_checks++;
        if (n_consumed - c0 < 4) $display("FAIL stall_resume: got %0d required >=4", n_consumed - c0);
        else n_pass++;
    endtask

    task automatic test_redirect();
        logic found;
        logic [31:0] pc;
        mem_lat = 3;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        step();
        n_checks++;
        if (bus.imem_req_valid !== 1'b0)
            $display("FAIL two_inflight_req: got %b required 0", bus.imem_req_valid);
        else n_pass++;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if ({bus.if_valid, bus.misalign_pulse} !== 2'b00)
            $display("FAIL after_redirect: got ifv=%b mis=%b required 0 0", bus.if_valid, bus.misalign_pulse);
        else n_pass++;
        wait_valid("redirect", found, pc);
        n_checks++;
        if ({found, pc} !== {1'b1, 32'h100})
            $display("FAIL redirect_pc: got found=%b pc=%h required 1 00000100", found, pc);
        else n_pass++;
        repeat (6) step();
    endtask

    task automatic test_collide();
        logic found;
        logic [31:0] pc;
        mem_lat = 1;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.if_valid && bus.imem_rsp_valid) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) $display("FAIL collide_setup: got %b required 1", found);
        else n_pass++;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.if_valid !== 1'b0) $display("FAIL collide_flush: got if_valid=%b required 0", bus.if_valid);
        else n_pass++;
        wait_valid("collide", found, pc);
        n_checks++;
        if ({found, pc} !== {1'b1, 32'h200})
            $display("FAIL collide_pc: got found=%b pc=%h required 1 00000200", found, pc);
        else n_pass++;
    endtask

    task automatic test_misalign();
        logic found;
        logic [31:0] pc;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h102;
        step();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.misalign_pulse !== 1'b1) $display("FAIL misalign_on: got %b required 1", bus.misalign_pulse);
        else n_pass++;
        step();
        n_checks++;
        if (bus.misalign_pulse !== 1'b0) $display("FAIL misalign_off: got %b required 0", bus.misalign_pulse);
        else n_pass++;
        found = bus.if_valid;
        pc = bus.if_pc;
        if (!found) wait_valid("misalign", found, pc);
        n_checks++;
        if ({found, pc} !== {1'b1, 32'h100})
            $display("FAIL misalign_pc: got found=%b pc=%h required 1 00000100", found, pc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic found;
        logic [31:0] pc;
        mem_lat = 3;
        repeat (4) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h300;
        step();
        bus.redirect_pc = 32'h400;
        step();
        bus.redirect_valid = 1'b0;
        wait_valid("back_to_back", found, pc);
        n_checks++;
        if ({found, pc} !== {1'b1, 32'h400})
            $display("FAIL b2b_pc: got found=%b pc=%h required 1 00000400", found, pc);
        else n_pass++;
        repeat (8) step();
    endtask

    task automatic test_wrap_reset();
        logic [31:0] pcs [2];
        int n;
        logic found;
        logic [31:0] pc;
        mem_lat = 1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        n = 0;
        pcs[0] = '0;
        pcs[1] = '1;
        for (int i = 0; i < 30 && n < 2; i++) begin
            step();
            if (bus.if_valid) begin
                pcs[n] = bus.if_pc;
                n++;
            end
        end
        n_checks++;
        if ({pcs[0], pcs[1]} !== {32'hFFFF_FFFC, 32'h0})
            $display("FAIL wrap_pcs: got %h %h required fffffffc 00000000", pcs[0], pcs[1]);
        else n_pass++;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({bus.imem_req_valid, bus.imem_req_addr, bus.if_valid, bus.if_pc, bus.if_instr,
             bus.misalign_pulse} !== {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b0})
            $display("FAIL midreset_outputs: got reqv=%b addr=%h ifv=%b pc=%h instr=%h required 0 %h 0 0 0",
                     bus.imem_req_valid, bus.imem_req_addr, bus.if_valid, bus.if_pc, bus.if_instr, RESET_PC);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, RESET_PC})
            $display("FAIL restart_req: got v=%b addr=%h required v=1 addr=%h",
                     bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
        else n_pass++;
        wait_valid("restart", found, pc);
        n_checks++;
        if ({found, pc} !== {1'b1, RESET_PC})
            $display("FAIL restart_pc: got found=%b pc=%h required 1 %h", found, pc, RESET_PC);
        else n_pass++;
        repeat (5) step();
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_collide();
        test_misalign();
        test_back_to_back();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
